// File: rtl/keccak_pkg.sv
// Shared constants and FSM state type for the chi revaluation stage.
package keccak_pkg;

  localparam int unsigned SLICE_W    = 25;
  localparam int unsigned ROW_W      = 5;
  localparam int unsigned NUM_ROWS   = SLICE_W / ROW_W;
  localparam int unsigned NUM_SLICES = 64;
  localparam int unsigned DIM_W      = 6;
  localparam int unsigned ROW_CNT_W  = 3;

  typedef enum logic [2:0] {
    StIdle,
    StWaitIn,
    StRow,
    StEmit,
    StFinish
  } reval_state_e;

endpackage

// File: rtl/chi_row.sv
// Combinational chi on one 5-bit row; the x+1/x+2 neighbours wrap inside the row.
module chi_row
  import keccak_pkg::*;
(
  input  logic [ROW_W-1:0] row_in,
  output logic [ROW_W-1:0] row_out
);

  // out[x] = in[x] ^ (~in[x+1] & in[x+2]), indices modulo the row width
  always_comb begin
    for (int x = 0; x < ROW_W; x++) begin
      row_out[x] = row_in[x] ^ (~row_in[(x + 1) % ROW_W] & row_in[(x + 2) % ROW_W]);
    end
  end

endmodule

// File: rtl/chi_revaluate.sv
// Chi revaluation over a 64-slice round with valid/ready handshakes on both sides.
// Default build computes one row per cycle (5-cycle ROW phase). Defining REVAL_FAST_EN
// computes all rows in one cycle; handshakes and slice sequencing are unchanged.
module chi_revaluate
  import keccak_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SLICE_W-1:0] slice_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [SLICE_W-1:0] slice_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DIM_W-1:0]   reval_dim,
  output logic               reval_done,
  output logic               busy
);

  localparam logic [DIM_W-1:0]     LastDim = DIM_W'(NUM_SLICES - 1);
  localparam logic [ROW_CNT_W-1:0] LastRow = ROW_CNT_W'(NUM_ROWS - 1);

  reval_state_e         state_q;
  logic [SLICE_W-1:0]   in_q;
  logic [SLICE_W-1:0]   out_q;
  logic [ROW_CNT_W-1:0] row_cnt_q;

  assign slice_out = out_q;

`ifdef REVAL_FAST_EN
  logic [SLICE_W-1:0] fast_res;

  for (genvar g = 0; g < NUM_ROWS; g++) begin : g_rows
    chi_row u_chi_row (
      .row_in (in_q[ROW_W*g +: ROW_W]),
      .row_out(fast_res[ROW_W*g +: ROW_W])
    );
  end
`else
  logic [ROW_W-1:0] row_sel;
  logic [ROW_W-1:0] row_res;

  // Pick the latched row addressed by the row counter
  always_comb begin
    row_sel = '0;
    for (int y = 0; y < NUM_ROWS; y++) begin
      if (row_cnt_q == ROW_CNT_W'(y)) row_sel = in_q[ROW_W*y +: ROW_W];
    end
  end

  chi_row u_chi_row (
    .row_in (row_sel),
    .row_out(row_res)
  );
`endif

  // Round sequencing FSM; all handshake/status outputs are registered alongside the state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      in_q       <= '0;
      out_q      <= '0;
      row_cnt_q  <= '0;
      reval_dim  <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      reval_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StWaitIn;
            reval_dim <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
          end
        end
        StWaitIn: begin
          if (in_valid) begin
            in_q      <= slice_in;
            row_cnt_q <= '0;
            in_ready  <= 1'b0;
            state_q   <= StRow;
          end
        end
        StRow: begin
`ifdef REVAL_FAST_EN
          out_q     <= fast_res;
          out_valid <= 1'b1;
          state_q   <= StEmit;
`else
          for (int y = 0; y < NUM_ROWS; y++) begin
            if (row_cnt_q == ROW_CNT_W'(y)) out_q[ROW_W*y +: ROW_W] <= row_res;
          end
          row_cnt_q <= row_cnt_q + ROW_CNT_W'(1);
          if (row_cnt_q == LastRow) begin
            out_valid <= 1'b1;
            state_q   <= StEmit;
          end
`endif
        end
        StEmit: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (reval_dim == LastDim) begin
              reval_done <= 1'b1;
              state_q    <= StFinish;
            end else begin
              reval_dim <= reval_dim + DIM_W'(1);
              in_ready  <= 1'b1;
              state_q   <= StWaitIn;
            end
          end
        end
        StFinish: begin
          reval_done <= 1'b0;
          busy       <= 1'b0;
          state_q    <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
